maze_quest_fsm: RTL and testbench
=================================

Name: maze_quest_fsm

Overview:
- Parametrised successor to the fixed four-room adventure FSM: a ROWS x COLS grid of rooms with per-room wall masks, a sword pickup room, a dragon room and an optional move budget.
- The player steers with n/s/e/w. The block tracks position, sword possession and move count, and resolves the dragon fight to win or dead.
- Sits behind the board-level button synchroniser; its outputs drive the room LEDs and the status display.
- Adds features the earlier block lacked: legality checks for moves, bump/bad-command flags, edge-triggered command mode and starvation death.

Parameters:
- ROWS, 2, grid rows (>=1).
- COLS, 2, grid columns (>=1); room index r = row*COLS + col; N = ROWS*COLS.
- START_ROOM, 0, room entered at reset.
- SWORD_ROOM, 2, room where the sword is picked up.
- DRAGON_ROOM, 3, room holding the dragon; must differ from START_ROOM and SWORD_ROOM (elaboration $error otherwise).
- WALL_N, 0, N-bit mask; bit r set means the north exit of room r is blocked. WALL_S, WALL_E and WALL_W have the same default (0) and meaning for their sides.
- EDGE_MODE, 0, 0 = level commands (one move per cycle); 1 = a move only on press after all buttons released.
- MOVE_W, 8, move counter width.
- MAX_MOVES, 0, move budget; 0 = unlimited.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- n, s, e, w  in  1 each  direction buttons, already synchronised.
- room  out  RW  current room index, where RW = max(1, $clog2(N)).
- room_oh  out  N  one-hot copy of room.
- sw  out  1  sword held.
- d  out  1  dead.
- win  out  1  won.
- bump  out  1  one-cycle pulse: legal single-direction command blocked by a wall or grid edge.
- bad_cmd  out  1  one-cycle pulse: accepted command with more than one direction asserted.
- moves  out  MOVE_W  count of successful moves, saturating at all-ones.

Behaviour:
- All outputs are registered.
- Reset values: room = START_ROOM, room_oh = 1 << START_ROOM, sw = 0, d = 0, win = 0, bump = 0, bad_cmd = 0, moves = 0, state = ROAM, armed = 0.
- States: ROAM, FIGHT, DEAD, WIN (2-bit encoding; implementer's choice).
- Command acceptance:
  - EDGE_MODE = 0: any cycle with {n,s,e,w} != 0 is a command.
  - EDGE_MODE = 1: a command is accepted only when the vector is != 0 and armed = 1.
  - armed is set in any cycle the vector == 0 and cleared when a command is accepted. Buttons held through reset release therefore do not move the player.
- ROAM, accepted command with exactly one direction:
  - Target: n -> row-1, s -> row+1, e -> col+1, w -> col-1.
  - Blocked if it would leave the grid or the matching WALL_x bit of the current room is set. Blocked result: room unchanged and bump = 1 for the next cycle.
  - Otherwise room and room_oh update next cycle and moves increments (saturating).
- ROAM, accepted command with 2-4 directions: no move; bad_cmd = 1 for the next cycle.
- Zero directions: hold.
- Sword pickup: a move landing in SWORD_ROOM sets sw on the same edge as the room update. sw is sticky until reset.
- Dragon: a move landing in DRAGON_ROOM enters FIGHT on the same edge. FIGHT lasts exactly one cycle with inputs ignored. The following edge goes to WIN (win = 1) if sw = 1, else DEAD (d = 1).
- Starvation: if MAX_MOVES != 0 and a successful move makes moves == MAX_MOVES, the next state is DEAD on the same edge.
  - Priority: dragon entry > starvation. A final move into DRAGON_ROOM still fights.
- WIN and DEAD are absorbing until reset. In these states: inputs ignored, room frozen, bump = bad_cmd = 0, moves frozen.
- Reset asserted in any state, including mid-FIGHT, returns everything to the reset values asynchronously.
- win and d are never both 1.

Test Plan:
- Defaults, reset then level e for 1 cycle, then s for 1 cycle -> room 0 -> 1 -> 3; FIGHT for 1 cycle; then d = 1, win = 0, sw = 0, moves = 2.
- Defaults, s then e -> room 2 with sw = 1, then room 3; FIGHT; then win = 1, d = 0, moves = 2. Further button presses leave all outputs unchanged.
- Defaults, from room 0: press n, then w -> bump pulses 1 cycle each, room stays 0, moves = 0. Press n+e together -> bad_cmd pulses, no move.
- WALL_E = 4'b0001, press e in room 0 -> bump = 1, room stays 0; then s, e -> room 3 with sw = 1, then win.
- EDGE_MODE = 1, hold e for 5 cycles -> one move only (room 1, moves = 1). Release 1 cycle, press s -> room 3. Hold e through reset release -> no move until released.
- MAX_MOVES = 3, sequence e, w, e -> d = 1 after the third move. Separate run, MAX_MOVES = 2 with s, e -> FIGHT then win. Assert reset during FIGHT -> room = 0 and all flags 0 immediately.

Source files
------------

// File: rtl/maze_quest_fsm.sv
// Grid adventure FSM: the player walks a ROWS x COLS maze, may pick up a sword,
// and the dragon fight decides win or death. Optional edge-triggered commands and move budget.
module maze_quest_fsm #(
  parameter int                 ROWS        = 2,
  parameter int                 COLS        = 2,
  parameter int                 START_ROOM  = 0,
  parameter int                 SWORD_ROOM  = 2,
  parameter int                 DRAGON_ROOM = 3,
  parameter logic [ROWS*COLS-1:0] WALL_N    = '0,
  parameter logic [ROWS*COLS-1:0] WALL_S    = '0,
  parameter logic [ROWS*COLS-1:0] WALL_E    = '0,
  parameter logic [ROWS*COLS-1:0] WALL_W    = '0,
  parameter bit                 EDGE_MODE   = 1'b0,
  parameter int                 MOVE_W      = 8,
  parameter int                 MAX_MOVES   = 0
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           n,
  input  logic                                           s,
  input  logic                                           e,
  input  logic                                           w,
  output logic [$clog2((ROWS*COLS > 1) ? ROWS*COLS : 2)-1:0] room,
  output logic [ROWS*COLS-1:0]                           room_oh,
  output logic                                           sw,
  output logic                                           d,
  output logic                                           win,
  output logic                                           bump,
  output logic                                           bad_cmd,
  output logic [MOVE_W-1:0]                              moves
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2((N > 1) ? N : 2);

  typedef enum logic [1:0] {ROAM, FIGHT, DEAD, WIN} state_t;

  if (DRAGON_ROOM == START_ROOM || DRAGON_ROOM == SWORD_ROOM) begin : g_cfg_error
    $error("maze_quest_fsm: DRAGON_ROOM must differ from START_ROOM and SWORD_ROOM");
  end

  state_t            state_q, state_d;
  logic [3:0]        cmd;
  logic              active, accept;
  logic              armed, armed_d;
  logic              open;
  logic [RW-1:0]     tgt, room_d;
  logic [N-1:0]      room_oh_d;
  logic              sw_d, bump_d, bad_cmd_d;
  logic [MOVE_W-1:0] moves_d;
  int                row, col, tgt_i;

  assign cmd    = {n, s, e, w};
  assign active = |cmd;
  assign accept = active && (!EDGE_MODE || armed);

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    room_d    = room;
    room_oh_d = room_oh;
    sw_d      = sw;
    moves_d   = moves;
    bump_d    = 1'b0;
    bad_cmd_d = 1'b0;
    armed_d   = armed;
    open      = 1'b0;
    row       = int'(room) / COLS;
    col       = int'(room) % COLS;
    tgt_i     = int'(room);

    if (!active)     armed_d = 1'b1;
    else if (accept) armed_d = 1'b0;

    // Target room and legality of a single-direction command.
    unique case (cmd)
      4'b1000: begin open = (row > 0)        && !WALL_N[room]; tgt_i = int'(room) - COLS; end
      4'b0100: begin open = (row < ROWS - 1) && !WALL_S[room]; tgt_i = int'(room) + COLS; end
      4'b0010: begin open = (col < COLS - 1) && !WALL_E[room]; tgt_i = int'(room) + 1;    end
      4'b0001: begin open = (col > 0)        && !WALL_W[room]; tgt_i = int'(room) - 1;    end
      default: open = 1'b0;
    endcase
    tgt = RW'(tgt_i);

    unique case (state_q)
      ROAM: begin
        if (accept) begin
          if (!$onehot(cmd)) begin
            bad_cmd_d = 1'b1;
          end else if (!open) begin
            bump_d = 1'b1;
          end else begin
            room_d    = tgt;
            room_oh_d = N'(1) << tgt;
            if (moves != '1) moves_d = moves + MOVE_W'(1);
            if (tgt == RW'(SWORD_ROOM)) sw_d = 1'b1;
            // Dragon entry wins over starvation on the final move.
            if (tgt == RW'(DRAGON_ROOM))
              state_d = FIGHT;
            else if (MAX_MOVES != 0 && moves_d == MOVE_W'(MAX_MOVES))
              state_d = DEAD;
          end
        end
      end
      FIGHT:   state_d = sw ? WIN : DEAD;
      default: state_d = state_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ROAM;
      armed   <= 1'b0;
      room    <= RW'(START_ROOM);
      room_oh <= N'(1) << START_ROOM;
      sw      <= 1'b0;
      d       <= 1'b0;
      win     <= 1'b0;
      bump    <= 1'b0;
      bad_cmd <= 1'b0;
      moves   <= '0;
    end else begin
      state_q <= state_d;
      armed   <= armed_d;
      room    <= room_d;
      room_oh <= room_oh_d;
      sw      <= sw_d;
      d       <= (state_d == DEAD);
      win     <= (state_d == WIN);
      bump    <= bump_d;
      bad_cmd <= bad_cmd_d;
      moves   <= moves_d;
    end
  end

endmodule

// File: tb/tb_maze_quest_fsm.sv
// Directed scoreboard bench for maze_quest_fsm: five instances cover default,
// east-wall, edge-mode and two move-budget configurations.
module tb_maze_quest_fsm;

  typedef struct packed {
    logic [1:0] room;
    logic [3:0] room_oh;
    logic       sw;
    logic       d;
    logic       win;
    logic       bump;
    logic       bad_cmd;
    logic [7:0] moves;
  } out_t;

  typedef struct {
    string tag;
    int    unit;
    out_t  exp;
  } item_t;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] BN   = 4'b1000;
  localparam logic [3:0] BS   = 4'b0100;
  localparam logic [3:0] BE   = 4'b0010;
  localparam logic [3:0] BW   = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn [5];
  out_t       obs [5];
  item_t      sb [$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: WALL_E=0001, 2: EDGE_MODE=1, 3: MAX_MOVES=3, 4: MAX_MOVES=2
  for (genvar k = 0; k < 5; k++) begin : g_dut
    localparam logic [3:0] WE = (k == 1) ? 4'b0001 : 4'b0000;
    localparam bit         EM = (k == 2);
    localparam int         MM = (k == 3) ? 3 : ((k == 4) ? 2 : 0);
    logic [1:0] room;
    logic [3:0] room_oh;
    logic       sw, d, win, bump, bad_cmd;
    logic [7:0] moves;

    maze_quest_fsm #(.WALL_E(WE), .EDGE_MODE(EM), .MAX_MOVES(MM)) u_dut (
      .clk(clk), .reset(reset),
      .n(btn[k][3]), .s(btn[k][2]), .e(btn[k][1]), .w(btn[k][0]),
      .room(room), .room_oh(room_oh), .sw(sw), .d(d), .win(win),
      .bump(bump), .bad_cmd(bad_cmd), .moves(moves)
    );

    assign obs[k] = {room, room_oh, sw, d, win, bump, bad_cmd, moves};
  end

  function automatic out_t mk(int r, bit sw_, bit d_, bit win_, bit bump_, bit bad_, int mv);
    out_t o;
    o.room    = 2'(r);
    o.room_oh = 4'(1 << r);
    o.sw      = sw_;
    o.d       = d_;
    o.win     = win_;
    o.bump    = bump_;
    o.bad_cmd = bad_;
    o.moves   = 8'(mv);
    return o;
  endfunction

  task automatic push(string tag, int unit, out_t exp);
    item_t it;
    it.tag  = tag;
    it.unit = unit;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic compare_front();
    item_t it;
    out_t  got;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    it  = sb.pop_front();
    got = obs[it.unit];
    assert (got === it.exp) else begin
      bad++;
      $error("FAIL %s unit=%0d observed=%h expected=%h", it.tag, it.unit, got, it.exp);
    end
  endtask

  task automatic step(int unit, logic [3:0] cmd, string tag, out_t exp);
    btn[unit] = cmd;
    push(tag, unit, exp);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic do_reset(int unit, logic [3:0] held);
    btn[unit] = held;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push("reset_state", unit, mk(0, 0, 0, 0, 0, 0, 0));
    compare_front();
  endtask

  initial begin
    for (int k = 0; k < 5; k++) btn[k] = NONE;

    // Default grid: e, s into the dragon without the sword -> dead.
    do_reset(0, NONE);
    step(0, BE,   "a_east",      mk(1, 0, 0, 0, 0, 0, 1));
    step(0, BS,   "a_south",     mk(3, 0, 0, 0, 0, 0, 2));
    step(0, NONE, "a_dead",      mk(3, 0, 1, 0, 0, 0, 2));
    step(0, BW,   "a_frozen",    mk(3, 0, 1, 0, 0, 0, 2));

    // s picks up the sword, e fights and wins; later presses change nothing.
    do_reset(0, NONE);
    step(0, BS,   "b_sword",     mk(2, 1, 0, 0, 0, 0, 1));
    step(0, BE,   "b_fight",     mk(3, 1, 0, 0, 0, 0, 2));
    step(0, NONE, "b_win",       mk(3, 1, 0, 1, 0, 0, 2));
    step(0, BN,   "b_frozen_n",  mk(3, 1, 0, 1, 0, 0, 2));
    step(0, 4'b0101, "b_frozen_multi", mk(3, 1, 0, 1, 0, 0, 2));

    // Grid edges bump; multi-direction flags bad_cmd.
    do_reset(0, NONE);
    step(0, BN,   "c_bump_n",    mk(0, 0, 0, 0, 1, 0, 0));
    step(0, BW,   "c_bump_w",    mk(0, 0, 0, 0, 1, 0, 0));
    step(0, NONE, "c_bump_clr",  mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 4'b1010, "c_bad_cmd", mk(0, 0, 0, 0, 0, 1, 0));
    step(0, NONE, "c_bad_clr",   mk(0, 0, 0, 0, 0, 0, 0));

    // East wall on room 0.
    do_reset(1, NONE);
    step(1, BE,   "d_wall_bump", mk(0, 0, 0, 0, 1, 0, 0));
    step(1, BS,   "d_sword",     mk(2, 1, 0, 0, 0, 0, 1));
    step(1, BE,   "d_fight",     mk(3, 1, 0, 0, 0, 0, 2));
    step(1, NONE, "d_win",       mk(3, 1, 0, 1, 0, 0, 2));

    // Edge mode: a held button moves once.
    do_reset(2, NONE);
    step(2, NONE, "e_arm",       mk(0, 0, 0, 0, 0, 0, 0));
    step(2, BE,   "e_press",     mk(1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) step(2, BE, "e_hold", mk(1, 0, 0, 0, 0, 0, 1));
    step(2, NONE, "e_release",   mk(1, 0, 0, 0, 0, 0, 1));
    step(2, BS,   "e_south",     mk(3, 0, 0, 0, 0, 0, 2));
    step(2, NONE, "e_dead",      mk(3, 0, 1, 0, 0, 0, 2));
    do_reset(2, BE);
    step(2, BE,   "e_held_rst1", mk(0, 0, 0, 0, 0, 0, 0));
    step(2, BE,   "e_held_rst2", mk(0, 0, 0, 0, 0, 0, 0));
    step(2, NONE, "e_rearm",     mk(0, 0, 0, 0, 0, 0, 0));
    step(2, BE,   "e_after_rel", mk(1, 0, 0, 0, 0, 0, 1));

    // Budget of three moves starves.
    do_reset(3, NONE);
    step(3, BE,   "f_m1",        mk(1, 0, 0, 0, 0, 0, 1));
    step(3, BW,   "f_m2",        mk(0, 0, 0, 0, 0, 0, 2));
    step(3, BE,   "f_starve",    mk(1, 0, 1, 0, 0, 0, 3));
    step(3, BS,   "f_frozen",    mk(1, 0, 1, 0, 0, 0, 3));

    // Budget of two: final move into the dragon still fights.
    do_reset(4, NONE);
    step(4, BS,   "g_sword",     mk(2, 1, 0, 0, 0, 0, 1));
    step(4, BE,   "g_fight",     mk(3, 1, 0, 0, 0, 0, 2));
    step(4, NONE, "g_win",       mk(3, 1, 0, 1, 0, 0, 2));

    // Reset asserted in the middle of FIGHT clears immediately.
    do_reset(4, NONE);
    step(4, BS,   "h_sword",     mk(2, 1, 0, 0, 0, 0, 1));
    step(4, BE,   "h_fight",     mk(3, 1, 0, 0, 0, 0, 2));
    reset = 1'b1;
    #1;
    push("h_async_reset", 4, mk(0, 0, 0, 0, 0, 0, 0));
    compare_front();
    @(posedge clk);
    #1;
    push("h_reset_held", 4, mk(0, 0, 0, 0, 0, 0, 0));
    compare_front();
    reset = 1'b0;
    step(4, NONE, "h_after_rst", mk(0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
